// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one binary-to-Gray result register between NREQ requesters.
// Optional GRAY_CONV_PARITY_EN adds a registered gray_par output (XOR-reduction of gray_out).

module gray_conv_lane #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);
  assign gray = bin ^ (bin >> 1);
endmodule

module gray_conv_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   din,
  output logic [NREQ-1:0]         gnt,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        gray_out,
  output logic [$clog2(NREQ)-1:0] out_id,
`ifdef GRAY_CONV_PARITY_EN
  output logic                    gray_par,
`endif
  output logic                    busy
);
  localparam int IDW = $clog2(NREQ);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                      state, state_d;
  logic [IDW-1:0]              ptr, ptr_nxt;
  logic [IDW-1:0]              win_idx;
  logic                        win_vld;
  logic                        accept;
  logic [NREQ-1:0][WIDTH-1:0]  gray_lane;

  // every requester gets its own converter; the winner's result is muxed into the register
  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    gray_conv_lane #(.WIDTH(WIDTH)) u_lane (
      .bin  (din[i*WIDTH +: WIDTH]),
      .gray (gray_lane[i])
    );
  end

  // rotating priority: first set req bit at or after ptr wins
  always_comb begin
    logic [IDW-1:0] cand;
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(ptr) + k) % NREQ);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign ptr_nxt = (win_idx == IDW'(NREQ-1)) ? '0 : win_idx + 1'b1;

  always_comb begin
    accept  = rst_n && win_vld && (state == IDLE || out_ready);
    state_d = state;
    gnt     = '0;
    if (accept) gnt = NREQ'(1) << win_idx;
    case (state)
      IDLE:    if (accept) state_d = HOLD;
      HOLD:    if (out_ready && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      gray_out <= '0;
      out_id   <= '0;
`ifdef GRAY_CONV_PARITY_EN
      gray_par <= 1'b0;
`endif
    end else begin
      state <= state_d;
      if (accept) begin
        ptr      <= ptr_nxt;
        gray_out <= gray_lane[win_idx];
        out_id   <= win_idx;
`ifdef GRAY_CONV_PARITY_EN
        gray_par <= ^gray_lane[win_idx];
`endif
      end
    end
  end

  assign out_valid = (state == HOLD);
  assign busy      = (state == HOLD);

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Scoreboard bench for gray_conv_arbiter: stimulus pushes hand-computed results, a monitor pops on handshake.

module tb_gray_conv_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] din;
  logic [3:0]  gnt;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  gray_out;
  logic [1:0]  out_id;
  logic        busy;
`ifdef GRAY_CONV_PARITY_EN
  logic        gray_par;
`endif

  typedef struct {
    logic [1:0] id;
    logic [3:0] gray;
    logic       par;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  gray_conv_arbiter #(.WIDTH(4), .NREQ(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .din       (din),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .gray_out  (gray_out),
    .out_id    (out_id),
`ifdef GRAY_CONV_PARITY_EN
    .gray_par  (gray_par),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] id, input logic [3:0] g);
    exp_t e;
    e.id   = id;
    e.gray = g;
    e.par  = ^g;
    sb.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // monitor: pop and compare whenever a result is handed off
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_result", {26'd0, out_id, gray_out}, 32'hffff_ffff);
        end else begin
          e = sb.pop_front();
          chk("sb_gray", gray_out, e.gray);
          chk("sb_id", out_id, e.id);
`ifdef GRAY_CONV_PARITY_EN
          chk("sb_par", gray_par, e.par);
`endif
        end
      end
    end
  end

  logic [3:0] rr_gnt  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] rr_gray [5] = '{4'b0001, 4'b0011, 4'b0010, 4'b1000, 4'b0001};
  logic [1:0] rr_id   [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  initial begin
    rst_n     = 1'b0;
    req       = 4'b1111;
    din       = {4'b1111, 4'b0011, 4'b0010, 4'b0001};
    out_ready = 1'b1;

    // reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_gray_out", gray_out, 4'b0000);
    chk("rst_out_id", out_id, 2'd0);
    chk("rst_busy", busy, 1'b0);

    // release with all requesting: round robin from requester 0, no bubbles
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("rr_gnt", gnt, rr_gnt[i]);
      if (i > 0) chk("rr_no_bubble", out_valid, 1'b1);
      push(rr_id[i], rr_gray[i]);
      tick();
    end
    req = 4'b0000;
    tick();
    #1;
    chk("rr_drain_idle", out_valid, 1'b0);

    // single request
    din[3:0] = 4'b0101;
    req      = 4'b0001;
    #1;
    chk("single_gnt", gnt, 4'b0001);
    push(2'd0, 4'b0111);
    tick();
    req = 4'b0000;
    #1;
    chk("single_valid", out_valid, 1'b1);
    chk("single_gray", gray_out, 4'b0111);
    chk("single_id", out_id, 2'd0);
    tick();
    #1;
    chk("single_drop", out_valid, 1'b0);

    // backpressure
    req       = 4'b0001;
    out_ready = 1'b0;
    #1;
    chk("bp_load_gnt", gnt, 4'b0001);
    push(2'd0, 4'b0111);
    for (int i = 0; i < 3; i++) begin
      tick();
      req = 4'b0010;
      #1;
      chk("bp_gnt", gnt, 4'b0000);
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_gray", gray_out, 4'b0111);
      chk("bp_id", out_id, 2'd0);
    end
    tick();
    out_ready = 1'b1;
    #1;
    chk("bp_release_gnt", gnt, 4'b0010);
    push(2'd1, 4'b0011);
    tick();
    req = 4'b0000;
    tick();
    #1;
    chk("bp_drain_idle", out_valid, 1'b0);

    // async reset while holding a result
    din[11:8] = 4'b0011;
    req       = 4'b0100;
    out_ready = 1'b0;
    #1;
    chk("ar_gnt", gnt, 4'b0100);
    tick();
    req = 4'b0000;
    #1;
    chk("ar_hold_valid", out_valid, 1'b1);
    chk("ar_hold_busy", busy, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_valid_drop", out_valid, 1'b0);
    chk("ar_busy_drop", busy, 1'b0);
    chk("ar_gray_clr", gray_out, 4'b0000);
    tick();
    rst_n     = 1'b1;
    req       = 4'b1111;
    out_ready = 1'b1;
    #1;
    chk("ar_ptr_zero_gnt", gnt, 4'b0001);
    push(2'd0, 4'b0111);
    tick();
    req = 4'b0000;
    tick();

`ifdef GRAY_CONV_PARITY_EN
    din[7:4] = 4'b0110;
    req      = 4'b0010;
    #1;
    chk("par_gnt0", gnt, 4'b0010);
    push(2'd1, 4'b0101);
    tick();
    din[7:4] = 4'b0111;
    #1;
    chk("par_gray0", gray_out, 4'b0101);
    chk("par_bit0", gray_par, 1'b0);
    chk("par_gnt1", gnt, 4'b0010);
    push(2'd1, 4'b0100);
    tick();
    req = 4'b0000;
    #1;
    chk("par_gray1", gray_out, 4'b0100);
    chk("par_bit1", gray_par, 1'b1);
    tick();
`endif

    tick();
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end
endmodule
